inst_mem_sync: RTL
==================

INST_MEM_SYNC -- requirements
Module: inst_mem_sync

Interface
REQ-001 Parameter WIDTH, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 1024, number of instruction words.
REQ-003 Parameter ADDR_W, default 32, byte-address width.
REQ-004 Parameter NOP_WORD, default all-zero, word returned for flush/out-of-range/reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 fetch_en  in  1  fetch request; 0 = stall (hold outputs).
REQ-008 adrs  in  ADDR_W  byte address; word index = adrs >> 2.
REQ-009 flush  in  1  discard pending fetch, output NOP.
REQ-010 inst  out  WIDTH  registered instruction word.
REQ-011 inst_valid  out  1  inst holds a fetched word.
REQ-012 addr_err  out  1  accompanying fetch was misaligned or out of range.
REQ-013 load_start  in  1  enter program-load mode, load pointer := 0.
REQ-014 load_valid  in  1  load_data is written at load pointer this cycle.
REQ-015 load_data  in  WIDTH  program word to write.
REQ-016 load_done  in  1  leave program-load mode.
REQ-017 busy  out  1  high while in LOAD state.
REQ-018 load_count  out  clog2(DEPTH+1)  number of words written since last load_start.

Function
REQ-019 FSM states IDLE, LOAD, RUN; reset state IDLE.
REQ-020 IDLE: load_start -> LOAD; fetch_en ignored, inst_valid stays 0.
REQ-021 LOAD: each cycle with load_valid writes load_data to word[load_count] and increments load_count; load_valid in the load_start cycle itself is ignored.
REQ-022 LOAD -> RUN on load_done, or automatically on the write that makes load_count == DEPTH; load_valid with load_done in same cycle: write occurs, then RUN.
REQ-023 load_valid when load_count == DEPTH shall be ignored (no wrap, no write).
REQ-024 load_start in LOAD or RUN: pointer and load_count reset to 0, state LOAD, inst := NOP_WORD, inst_valid := 0, addr_err := 0.
REQ-025 RUN read latency exactly 1 cycle: fetch_en=1 at edge N -> inst = word[adrs>>2], inst_valid = 1 after edge N.
REQ-026 RUN, fetch_en=0 and flush=0: inst, inst_valid, addr_err hold previous values (stall).
REQ-027 flush=1 (any state) has priority over fetch_en: inst := NOP_WORD, inst_valid := 0, addr_err := 0 next cycle.
REQ-028 Word index >= DEPTH: inst := NOP_WORD, inst_valid := 1, addr_err := 1; memory not accessed.
REQ-029 adrs[1:0] != 0: addr_err := 1, word still fetched from adrs>>2 (if in range), inst_valid := 1.
REQ-030 Words never written since power-up read as undefined; memory array is not cleared by reset.
REQ-031 busy = 1 iff state == LOAD (combinational from state).
REQ-032 load_count retains its value in RUN and IDLE until the next load_start.

Reset
REQ-033 rst low asynchronously forces: state IDLE, inst = NOP_WORD, inst_valid = 0, addr_err = 0, busy = 0, load_count = 0.
REQ-034 rst asserted mid-LOAD abandons load; words already written remain in the array.
REQ-035 First active edge after rst deasserts is processed normally.

Verification
REQ-036 Reset, load_start, load 4 words 0x8001060A,0x04011000,0x0C011800,0x00000000, load_done -> busy 1 for 5 cycles, load_count = 4, state RUN.
REQ-037 RUN, fetch adrs=0x4 -> next cycle inst = 0x04011000, inst_valid = 1, addr_err = 0; then fetch_en=0 for 3 cycles -> inst unchanged.
REQ-038 DEPTH=1024, fetch adrs=0x1000 -> inst = NOP_WORD, inst_valid = 1, addr_err = 1; fetch adrs=0x6 -> inst = 0x04011000, addr_err = 1.
REQ-039 flush and fetch_en both high with adrs=0x0 -> inst = NOP_WORD, inst_valid = 0.
REQ-040 DEPTH=4: 5 load_valid cycles -> state RUN after 4th write, load_count = 4, 5th word dropped, word[0] unchanged.
REQ-041 rst pulsed low mid-cycle during RUN -> outputs reset immediately without clock edge; subsequent fetch before new load returns inst_valid = 0.

Source files
------------

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory with a program-load port and 1-cycle registered fetch.
// A load session fills words from index 0 upward; RUN serves fetches with alignment/range flags.
module inst_mem_sync #(
  parameter int unsigned        WIDTH    = 32,
  parameter int unsigned        DEPTH    = 1024,
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [WIDTH-1:0]   NOP_WORD = '0,
  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] adrs,
  input  logic              flush,
  output logic [WIDTH-1:0]  inst,
  output logic              inst_valid,
  output logic              addr_err,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              load_done,
  output logic              busy,
  output logic [CNT_W-1:0]  load_count
);

  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IDX_W  = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [IDX_W-1:0]  word_idx;
  logic              in_range_c;
  logic              misaligned_c;
  logic              full_c;
  logic              wr_en_c;
  logic [CNT_W-1:0]  cnt_next_c;

  assign word_idx     = adrs[ADDR_W-1:2];
  assign in_range_c   = (64'(word_idx) < 64'(DEPTH));
  assign misaligned_c = |adrs[1:0];
  assign full_c       = (load_count == CNT_W'(DEPTH));
  assign cnt_next_c   = load_count + CNT_W'(1);
  // load_start restarts the session, so a load_valid in that same cycle is dropped
  assign wr_en_c      = (state == LOAD) && !load_start && load_valid && !full_c;
  assign busy         = (state == LOAD);

  // Array has no reset: contents survive rst and are only changed by load writes
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[MEM_AW'(load_count)] <= load_data;
    end
  end

  // Control FSM with registered fetch outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      inst       <= NOP_WORD;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
      load_count <= '0;
    end else if (load_start) begin
      state      <= LOAD;
      load_count <= '0;
      inst       <= NOP_WORD;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      if (flush) begin
        inst       <= NOP_WORD;
        inst_valid <= 1'b0;
        addr_err   <= 1'b0;
      end else if ((state == RUN) && fetch_en) begin
        inst_valid <= 1'b1;
        addr_err   <= misaligned_c || !in_range_c;
        inst       <= in_range_c ? mem[MEM_AW'(word_idx)] : NOP_WORD;
      end

      if (state == LOAD) begin
        if (wr_en_c) begin
          load_count <= cnt_next_c;
        end
        // Filling the last word ends the session even without load_done
        if (load_done || (wr_en_c && (cnt_next_c == CNT_W'(DEPTH)))) begin
          state <= RUN;
        end
      end
    end
  end

endmodule
